vga_timing_gen: RTL and testbench

Generates raster timing for the VGA output path from the 100 MHz system clock. It produces a pixel clock-enable, horizontal/vertical pixel counters, sync pulses and an active-video flag. It sits directly upstream of the dithering stage and supplies that stage's hc/vc inputs (bit 0 of each counter). It also gives the colour source its pixel coordinates.

---
 rtl/vga_timing_gen_pkg.sv | 28 ++
 rtl/vga_timing_gen_pix_ce_div.sv | 30 +++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions: default 640x480@60 timing set, total
// line/frame length helpers and the coordinate type.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 10;

    // Pixels per line including blanking.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef logic [DEF_CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Clock-enable divider: produces a one-clk pulse every CLK_DIV clks.
// The first pulse appears CLK_DIV clks after reset is released.
module pix_ce_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic ce
);

    localparam int            W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    // Count 0..CLK_DIV-1 and register a pulse on the clk after the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + W'(1);
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, h/v counters, sync pulses,
// active-video flag and a frame-start pulse. All outputs are registered and
// the syncs/visible flag are derived from the next counter values so they
// line up with hc/vc on the same clk.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_ce,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // One extra bit on the window bounds so a window ending exactly at
    // 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0]   HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W:0]   H_VIS    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_VIS    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic             ce;
    logic [CNT_W-1:0] hc_next;
    logic [CNT_W-1:0] vc_next;
    logic             frame_wrap;
    logic             hs_act;
    logic             vs_act;
    logic             vis_next;

    pix_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .ce  (ce)
    );

    // Next raster position: compare against the last value before
    // incrementing so neither counter ever reaches its total.
    always_comb begin
        hc_next    = hc;
        vc_next    = vc;
        frame_wrap = 1'b0;
        if (ce) begin
            if (hc == H_LAST) begin
                hc_next = '0;
                if (vc == V_LAST) begin
                    vc_next    = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vc_next = vc + CNT_W'(1);
                end
            end else begin
                hc_next = hc + CNT_W'(1);
            end
        end
    end

    // Sync windows and active area evaluated on the next position.
    always_comb begin
        hs_act   = ({1'b0, hc_next} >= HS_START) && ({1'b0, hc_next} < HS_END);
        vs_act   = ({1'b0, vc_next} >= VS_START) && ({1'b0, vc_next} < VS_END);
        vis_next = ({1'b0, hc_next} < H_VIS) && ({1'b0, vc_next} < V_VIS);
    end

    // Register position, syncs, visible flag and the frame-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            visible     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            visible     <= vis_next;
            frame_start <= frame_wrap;
        end
    end

    assign pix_ce = ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default timing, a small
// timing set that makes whole frames short, and CLK_DIV=1 with positive
// syncs), a closed-form reference model feeding per-instance scoreboards,
// plus targeted pulse/window counts.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: default 640x480 timing, CLK_DIV=4, active-low syncs
    logic       pce0, hs0, vs0, vis0, fs0;
    logic [9:0] hc0, vc0;
    // Instance 1: small raster, CNT_W=5
    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME = (S_HA+S_HF+S_HS+S_HB) * (S_VA+S_VF+S_VS+S_VB);
    logic       pce1, hs1, vs1, vis1, fs1;
    logic [4:0] hc1, vc1;
    // Instance 2: default timing, CLK_DIV=1, active-high syncs
    logic       pce2, hs2, vs2, vis2, fs2;
    logic [9:0] hc2, vc2;

    vga_timing_gen dut0 (
        .clk(clk), .rst(rst0), .pix_ce(pce0), .hc(hc0), .vc(vc0),
        .hsync(hs0), .vsync(vs0), .visible(vis0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0), .CNT_W(5)
    ) dut1 (
        .clk(clk), .rst(rst1), .pix_ce(pce1), .hc(hc1), .vc(vc1),
        .hsync(hs1), .vsync(vs1), .visible(vis1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst0), .pix_ce(pce2), .hc(hc2), .vc(vc2),
        .hsync(hs2), .vsync(vs2), .visible(vis2), .frame_start(fs2)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one of the two reset lines
    task automatic applyStimulus(input int which, input logic value);
        if (which == 0) rst0 = value;
        else            rst1 = value;
    endtask

    // Closed-form reference: t = clk edges since reset release.
    // Returns {pix_ce, hc[9:0], vc[9:0], hsync, vsync, visible, frame_start}.
    function automatic logic [24:0] model(input int t, input int d,
                                          input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb,
                                          input logic pol);
        int ht, vt, n, h, v;
        logic ce, adv, fs, hs, vs, vis;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        ce  = (t >= d) && ((t % d) == 0);
        n   = (t >= 1) ? (t - 1) / d : 0;
        adv = (t >= 1) && ((t - 1) >= d) && (((t - 1) % d) == 0);
        h   = n % ht;
        v   = (n / ht) % vt;
        fs  = adv && (n > 0) && ((n % (ht * vt)) == 0);
        hs  = ((h >= ha + hf) && (h < ha + hf + hsw)) ? pol : ~pol;
        vs  = ((v >= va + vf) && (v < va + vf + vsw)) ? pol : ~pol;
        vis = (h < ha) && (v < va);
        return {ce, 10'(h), 10'(v), hs, vs, vis, fs};
    endfunction

    int t0 = 0;
    int t1 = 0;
    logic [24:0] q0[$];
    logic [24:0] q1[$];
    logic [24:0] q2[$];

    // On each edge, advance the model time and queue the expected outputs
    always @(posedge clk) begin
        q0.push_back(model(rst0 ? 0 : t0 + 1, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        q1.push_back(model(rst1 ? 0 : t1 + 1, 4, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0));
        q2.push_back(model(rst0 ? 0 : t0 + 1, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
        t0 <= rst0 ? 0 : t0 + 1;
        t1 <= rst1 ? 0 : t1 + 1;
    end

    // Away from the active edge, pop the expectations and compare
    always @(negedge clk) begin
        if (q0.size() > 0)
            checkOutput("sb_dut0", {7'b0, pce0, hc0, vc0, hs0, vs0, vis0, fs0}, {7'b0, q0.pop_front()});
        if (q1.size() > 0)
            checkOutput("sb_dut1", {7'b0, pce1, 5'b0, hc1, 5'b0, vc1, hs1, vs1, vis1, fs1}, {7'b0, q1.pop_front()});
        if (q2.size() > 0)
            checkOutput("sb_dut2", {7'b0, pce2, hc2, vc2, hs2, vs2, vis2, fs2}, {7'b0, q2.pop_front()});
    end

    int cnt;
    int cnt2;
    int guard;

    initial begin
        $display("[TB] start");
        applyStimulus(0, 1'b1);
        applyStimulus(1, 1'b1);
        repeat (3) @(negedge clk);

        // Reset values while reset is held
        checkOutput("rst_pix_ce", {31'b0, pce0}, 32'd0);
        checkOutput("rst_hc", {22'b0, hc0}, 32'd0);
        checkOutput("rst_vc", {22'b0, vc0}, 32'd0);
        checkOutput("rst_syncs", {30'b0, hs0, vs0}, 32'd3);
        checkOutput("rst_visible", {31'b0, vis0}, 32'd1);
        checkOutput("rst_frame_start", {31'b0, fs0}, 32'd0);
        checkOutput("rst_syncs_pos", {30'b0, hs2, vs2}, 32'd0);

        applyStimulus(0, 1'b0);
        applyStimulus(1, 1'b0);

        // Latency from release to first pix_ce
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!pce0 && cnt < 20);
        checkOutput("first_pix_ce_latency", cnt, 32'd4);

        // Pulse period and width
        cnt = 0;
        cnt2 = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (pce0) cnt2++;
        end while (!pce0 && cnt < 20);
        checkOutput("pix_ce_period", cnt, 32'd4);
        @(negedge clk);
        checkOutput("pix_ce_width", {31'b0, pce0}, 32'd0);

        // One full line of pixel slots on the default instance
        cnt = 0;
        cnt2 = 0;
        guard = 0;
        for (int i = 0; i < 800 && guard < 4000; ) begin
            @(negedge clk);
            guard++;
            if (pce0) begin
                i++;
                if (hs0 == 1'b0) cnt++;
                if (vis0) cnt2++;
            end
        end
        checkOutput("hsync_low_pixels", cnt, 32'd96);
        checkOutput("visible_pixels", cnt2, 32'd640);

        // Line wrap observed on the default instance: after hc=799 comes hc=0
        guard = 0;
        while (!(hc0 == 10'd799 && pce0) && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checkOutput("line_wrap_hc", {22'b0, hc0}, 32'd0);
        checkOutput("line_wrap_fs", {31'b0, fs0}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("hold_hc_without_ce", {22'b0, hc0}, 32'd0);

        // Positive-sync CLK_DIV=1 instance: hsync high for 96 of 800 pixels
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (hs2) cnt++;
            if (pce2) cnt2++;
        end
        checkOutput("pos_hsync_pixels", cnt, 32'd96);
        checkOutput("div1_pix_ce_every_clk", cnt2, 32'd800);

        // Frame length on the small instance, frame_start to frame_start
        guard = 0;
        while (!fs1 && guard < 4 * S_FRAME + 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("frame_start_seen", {31'b0, fs1}, 32'd1);
        checkOutput("frame_start_pos", {27'b0, hc1, vc1}, 32'd0);
        @(negedge clk);
        checkOutput("frame_start_width", {31'b0, fs1}, 32'd0);
        cnt = 0;
        guard = 0;
        while (!fs1 && guard < 4 * S_FRAME + 10) begin
            if (pce1) cnt++;
            @(negedge clk);
            guard++;
        end
        checkOutput("pix_ce_per_frame", cnt, S_FRAME);

        // Mid-frame reset on the small instance
        guard = 0;
        while (!(hc1 == 5'd10 && vc1 == 5'd5) && guard < 4 * S_FRAME + 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_mid_frame", {27'b0, hc1, vc1}, {22'b0, 5'd10, 5'd5});
        applyStimulus(1, 1'b1);
        @(negedge clk);
        checkOutput("mid_rst_pos", {27'b0, hc1, vc1}, 32'd0);
        checkOutput("mid_rst_syncs", {30'b0, hs1, vs1}, 32'd3);
        checkOutput("mid_rst_pix_ce", {31'b0, pce1}, 32'd0);
        applyStimulus(1, 1'b0);
        cnt = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (pce1) cnt++;
        end while (!fs1 && guard < 4 * S_FRAME + 10);
        checkOutput("frame_after_mid_rst", cnt, S_FRAME);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
